// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline datapath.
// master = hazard controller (reads decoded fields, drives stall/flush controls)
// slave  = pipeline datapath (drives decoded fields, obeys controls)
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  // decoded pipeline state presented to the controller
  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       ex_rd;
  logic             ex_mem_read;
  logic             branch_taken;
  logic             dmem_busy;
  // pipeline register controls
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             ex_mem_hold;
  // status / performance
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    input  id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, dmem_busy,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
    output mem_timeout, stall_cycles, flush_events
  );

  modport slave (
    output id_opcode, id_rs1, id_rs2, ex_rd, ex_mem_read, branch_taken, dmem_busy,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold,
    input  mem_timeout, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use detection,
// branch flush sequencing, data-memory wait holds, perf counters and a
// sticky memory-timeout flag. Controls are combinational from state+inputs.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  pipeline_hazard_ctrl_if.master  hz
);
  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam int WC_W = (MEM_TIMEOUT  < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_FLUSH    = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  state_e            ret_q, ret_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  flush_ev_q, flush_ev_d;
  logic              tmo_q, tmo_d;

  logic pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_hold;
  logic uses_rs1, uses_rs2, load_use, flush_inc;

  // Decode which source registers the instruction in ID actually reads;
  // LUI/AUIPC/JAL carry garbage in the rs1 field and must not stall.
  always_comb begin
    uses_rs1 = !(hz.id_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
    uses_rs2 =   hz.id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) &&
               ((uses_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                (uses_rs2 && (hz.id_rs2 == hz.ex_rd)));
  end

  // Next-state, control outputs and counter updates.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    flush_inc    = 1'b0;
    state_d      = state_q;
    ret_d        = ret_q;
    flush_cnt_d  = flush_cnt_q;
    wait_cnt_d   = wait_cnt_q;

    if (!reset_i) begin
      // keep the pipeline filled with bubbles while in reset
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (hz.dmem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            state_d     = S_MEM_WAIT;
            ret_d       = S_RUN;
            wait_cnt_d  = WC_W'(1);
          end else if (hz.branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = S_FLUSH;
              flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
            end
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        S_FLUSH: begin
          if (hz.dmem_busy) begin
            // memory hold wins; remaining flush cycles resume after the wait
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            state_d     = S_MEM_WAIT;
            ret_d       = S_FLUSH;
            wait_cnt_d  = WC_W'(1);
          end else begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_cnt_d  = flush_cnt_q - FC_W'(1);
            if (flush_cnt_q == FC_W'(1)) state_d = S_RUN;
          end
        end
        S_MEM_WAIT: begin
          if (hz.dmem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
            if (wait_cnt_q < WC_W'(MEM_TIMEOUT)) wait_cnt_d = wait_cnt_q + WC_W'(1);
          end else begin
            state_d    = ret_q;
            wait_cnt_d = '0;
          end
        end
        default: state_d = S_RUN;
      endcase
    end

    tmo_d      = tmo_q | (hz.dmem_busy && (wait_cnt_d == WC_W'(MEM_TIMEOUT)));
    stall_d    = (!pc_write && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    flush_ev_d = (flush_inc && (flush_ev_q != '1)) ? flush_ev_q + CNT_W'(1) : flush_ev_q;
  end

  // State, counters and sticky flag; synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= S_RUN;
      ret_q       <= S_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
      stall_q     <= '0;
      flush_ev_q  <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_q     <= stall_d;
      flush_ev_q  <= flush_ev_d;
      tmo_q       <= tmo_d;
    end
  end

  assign hz.pc_write     = pc_write;
  assign hz.if_id_write  = if_id_write;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_bubble = id_ex_bubble;
  assign hz.ex_mem_hold  = ex_mem_hold;
  assign hz.mem_timeout  = tmo_q;
  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_ev_q;

endmodule
